miriscv_lsu: RTL and testbench

Load-store unit controller between the core datapath and the data-memory bus. It takes one memory micro-op per instruction from the decode/execute stage and checks alignment. It drives a request/grant/response handshake to data memory, with byte enables and write-data lane placement. It stalls the core until the access completes, then returns sign- or zero-extended load data.

---
 rtl/miriscv_lsu_pkg.sv | 68 ++++++
 rtl/miriscv_lsu_extend.sv | 39 +++
 rtl/miriscv_lsu.sv | 107 ++++++++++
 tb/tb_miriscv_lsu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : miriscv_lsu_pkg
//  Description : Shared constants, state encoding and helper functions for
//                the load-store unit (funct3 access sizes, FSM states,
//                legality check, byte-enable and store-lane placement).
//  Revision    : 1.0 - initial release
// ============================================================================
package miriscv_lsu_pkg;

  // funct3 encodings of the memory access size
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  // LSU controller states
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // An op is legal when its size exists, it is naturally aligned, and it is
  // not an unsigned store (stores have no signedness).
  function automatic logic lsu_op_legal(input logic       we,
                                        input logic [2:0] size,
                                        input logic [1:0] addr_lsb);
    logic ok;
    case (size)
      LDST_B:  ok = 1'b1;
      LDST_BU: ok = ~we;
      LDST_H:  ok = ~addr_lsb[0];
      LDST_HU: ok = ~addr_lsb[0] & ~we;
      LDST_W:  ok = (addr_lsb == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte enables for an aligned access of the given size
  function automatic logic [3:0] lsu_byte_en(input logic [2:0] size,
                                             input logic [1:0] addr_lsb);
    logic [3:0] be;
    case (size)
      LDST_B, LDST_BU: be = 4'b0001 << addr_lsb;
      LDST_H, LDST_HU: be = 4'b0011 << addr_lsb;
      default:         be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across all lanes so the enabled lanes carry it
  function automatic logic [31:0] lsu_wdata(input logic [2:0]  size,
                                            input logic [31:0] data);
    logic [31:0] wd;
    case (size)
      LDST_B, LDST_BU: wd = {4{data[7:0]}};
      LDST_H, LDST_HU: wd = {2{data[15:0]}};
      default:         wd = data;
    endcase
    return wd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/miriscv_lsu_extend.sv
`default_nettype none
// ============================================================================
//  Module      : miriscv_lsu_extend
//  Description : Combinational load-lane select with sign/zero extension of
//                a byte or half-word taken from the read word.
//  Revision    : 1.0 - initial release
// ============================================================================
module miriscv_lsu_extend
  import miriscv_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_addr_lsb,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane, then extend according to signedness
  always_comb begin
    case (i_addr_lsb)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lsb[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      LDST_B:  o_data = {{24{w_byte[7]}}, w_byte};
      LDST_BU: o_data = {24'd0, w_byte};
      LDST_H:  o_data = {{16{w_half[15]}}, w_half};
      LDST_HU: o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/miriscv_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : miriscv_lsu
//  Description : Load-store unit controller. Checks alignment, issues one
//                request/grant/response bus transaction per op, stalls the
//                core until completion and returns extended load data.
//  Revision    : 1.0 - initial release
// ============================================================================
module miriscv_lsu
  import miriscv_lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        arstn_i,
  // core side
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_misaligned_o,
  // data memory bus
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  lsu_state_e  r_state;
  logic [2:0]  r_size;
  logic [1:0]  r_addr_lsb;
  logic        w_legal;
  logic [31:0] w_load_ext;

  assign w_legal = lsu_op_legal(lsu_we_i, lsu_size_i, lsu_addr_i[1:0]);

  // Stall covers the accepting IDLE cycle plus every REQ/WAIT cycle
  assign lsu_stall_req_o  = ((r_state == LSU_IDLE) && lsu_req_i && w_legal) ||
                            (r_state == LSU_REQ) || (r_state == LSU_WAIT);
  assign lsu_misaligned_o = (r_state == LSU_IDLE) && lsu_req_i && !w_legal;

  miriscv_lsu_extend u_extend (
    .i_rdata    (data_rdata_i),
    .i_size     (r_size),
    .i_addr_lsb (r_addr_lsb),
    .o_data     (w_load_ext)
  );

  // Controller FSM with all bus outputs and load data held in registers
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state      <= LSU_IDLE;
      r_size       <= 3'd0;
      r_addr_lsb   <= 2'd0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'd0;
      data_addr_o  <= 32'd0;
      data_wdata_o <= 32'd0;
      lsu_data_o   <= 32'd0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (lsu_req_i && w_legal) begin
            r_state      <= LSU_REQ;
            r_size       <= lsu_size_i;
            r_addr_lsb   <= lsu_addr_i[1:0];
            data_req_o   <= 1'b1;
            data_we_o    <= lsu_we_i;
            data_be_o    <= lsu_byte_en(lsu_size_i, lsu_addr_i[1:0]);
            data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
            data_wdata_o <= lsu_wdata(lsu_size_i, lsu_data_i);
          end
        end
        LSU_REQ: begin
          // the request stays up until the bus takes it
          if (data_gnt_i) begin
            r_state    <= LSU_WAIT;
            data_req_o <= 1'b0;
          end
        end
        LSU_WAIT: begin
          if (data_rvalid_i) begin
            r_state <= LSU_DONE;
            if (!data_we_o) begin
              lsu_data_o <= w_load_ext;
            end
          end
        end
        LSU_DONE: begin
          // a request seen here is only taken in the following IDLE cycle
          r_state <= LSU_IDLE;
        end
        default: begin
          r_state <= LSU_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_miriscv_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_miriscv_lsu
//  Description : Self-checking bench for miriscv_lsu: directed cases plus
//                randomized ops compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_miriscv_lsu;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_size_i = 3'd0;
  logic [31:0] lsu_addr_i = 32'd0;
  logic [31:0] lsu_data_i = 32'd0;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o;
  logic        lsu_misaligned_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = 32'd0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_data = 32'd0;

  miriscv_lsu dut (
    .clk_i            (clk_i),
    .arstn_i          (arstn_i),
    .lsu_req_i        (lsu_req_i),
    .lsu_we_i         (lsu_we_i),
    .lsu_size_i       (lsu_size_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_data_i       (lsu_data_i),
    .lsu_data_o       (lsu_data_o),
    .lsu_stall_req_o  (lsu_stall_req_o),
    .lsu_misaligned_o (lsu_misaligned_o),
    .data_req_o       (data_req_o),
    .data_we_o        (data_we_o),
    .data_be_o        (data_be_o),
    .data_addr_o      (data_addr_o),
    .data_wdata_o     (data_wdata_o),
    .data_gnt_i       (data_gnt_i),
    .data_rvalid_i    (data_rvalid_i),
    .data_rdata_i     (data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int m_nbytes(input logic [2:0] size);
    return 1 << size[1:0];
  endfunction

  function automatic bit m_legal(input logic we, input logic [2:0] size, input logic [31:0] addr);
    int n;
    if (size == 3 || size == 6 || size == 7) return 0;
    if (we && size[2]) return 0;
    n = m_nbytes(size);
    return (addr % n) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] size, input logic [31:0] addr);
    int mask;
    mask = ((1 << m_nbytes(size)) - 1) << (addr % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] size, input logic [31:0] d);
    case (m_nbytes(size))
      1:       return {24'd0, d[7:0]} * 32'h0101_0101;
      2:       return {16'd0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] size, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int          bits;
    logic [31:0] v;
    logic [31:0] mask;
    bits = 8 * m_nbytes(size);
    v    = rdata >> (8 * (addr % 4));
    mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    v    = v & mask;
    if (!size[2] && bits < 32 && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // Runs one op; entered and left one time unit after a rising edge.
  task automatic do_op(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int gnt_dly, input int rv_dly, input bit spur);
    int st_cnt = 0, rq_cnt = 0, g = 0, r = 0;
    bit seen_req = 0, granted = 0, responded = 0, finished = 0;
    lsu_req_i  = 1'b1;
    lsu_we_i   = we;
    lsu_size_i = size;
    lsu_addr_i = addr;
    lsu_data_i = wdata;
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0;
    if (!m_legal(we, size, addr)) begin
      #1;
      check("mis_pulse", {31'd0, lsu_misaligned_o}, 32'd1);
      check("mis_stall", {31'd0, lsu_stall_req_o}, 32'd0);
      @(posedge clk_i); #1;
      lsu_req_i = 1'b0;
      #1;
      check("mis_no_req", {31'd0, data_req_o}, 32'd0);
      check("mis_end", {30'd0, lsu_misaligned_o, lsu_stall_req_o}, 32'd0);
      @(posedge clk_i); #1;
      return;
    end
    for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
      #1;
      if (lsu_stall_req_o) st_cnt++;
      if (data_req_o) begin
        rq_cnt++;
        if (!seen_req) begin
          seen_req = 1;
          check("bus_addr", data_addr_o, addr & 32'hFFFF_FFFC);
          check("bus_be", {28'd0, data_be_o}, {28'd0, m_be(size, addr)});
          check("bus_we", {31'd0, data_we_o}, {31'd0, we});
          if (we) check("bus_wdata", data_wdata_o, m_wdata(size, wdata));
        end
        data_gnt_i    = (g == gnt_dly);
        granted       = (g == gnt_dly);
        g++;
        data_rvalid_i = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        data_rdata_i  = $urandom;
      end else if (granted && !responded) begin
        data_gnt_i    = 1'($urandom_range(0, 1));
        data_rvalid_i = (r == rv_dly);
        data_rdata_i  = (r == rv_dly) ? rdata : $urandom;
        responded     = (r == rv_dly);
        r++;
      end else if (!lsu_stall_req_o && seen_req) begin
        finished      = 1;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        if (!we) exp_data = m_load(size, addr, rdata);
        check("load_data", lsu_data_o, exp_data);
        check("stall_cycles", st_cnt, 3 + gnt_dly + rv_dly);
        check("req_cycles", rq_cnt, 1 + gnt_dly);
      end else begin
        data_gnt_i    = 1'($urandom_range(0, 1));
        data_rvalid_i = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(posedge clk_i); #1;
    end
    if (!finished) check("op_timeout", 32'd0, 32'd1);
    lsu_req_i     = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_outputs", {data_req_o, data_we_o, data_be_o, lsu_stall_req_o, lsu_misaligned_o},
          32'd0);
    check("rst_data", lsu_data_o | data_addr_o | data_wdata_o, 32'd0);
    @(posedge clk_i); #1;
    arstn_i = 1'b1;
    @(posedge clk_i); #1;

    // directed cases
    do_op(1'b0, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0, 0);
    check("lw_result", lsu_data_o, 32'hDEADBEEF);
    do_op(1'b0, 3'd0, 32'h103, 32'd0, 32'h80112233, 0, 0, 0);
    check("lb_result", lsu_data_o, 32'hFFFFFF80);
    do_op(1'b0, 3'd4, 32'h103, 32'd0, 32'h80112233, 0, 0, 0);
    check("lbu_result", lsu_data_o, 32'h00000080);
    do_op(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'd0, 1, 0, 0);
    do_op(1'b0, 3'd2, 32'h101, 32'd0, 32'd0, 0, 0, 0);
    do_op(1'b1, 3'd4, 32'h300, 32'h55, 32'd0, 0, 0, 0);
    do_op(1'b0, 3'd2, 32'h400, 32'd0, 32'hCAFEF00D, 3, 2, 1);

    // asynchronous reset while in REQ (phase 1) and in WAIT (phase 2)
    for (int ph = 1; ph <= 2; ph++) begin
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h500;
      @(posedge clk_i); #1;
      data_gnt_i = (ph == 2);
      if (ph == 2) begin
        @(posedge clk_i); #1;
        data_gnt_i = 1'b0;
      end
      check("pre_rst_stall", {31'd0, lsu_stall_req_o}, 32'd1);
      #2;
      arstn_i   = 1'b0;
      lsu_req_i = 1'b0;
      #1;
      check("arst_bus", {data_req_o, data_we_o, data_be_o, lsu_stall_req_o}, 32'd0);
      check("arst_data", lsu_data_o, 32'd0);
      exp_data = 32'd0;
      @(posedge clk_i); #2;
      arstn_i = 1'b1;
      @(posedge clk_i); #1;
      do_op(1'b0, 3'd2, 32'h600, 32'd0, 32'h13572468, 0, 0, 0);
    end

    // randomized ops
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      a = $urandom & 32'h0000_FFFF;
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
